// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer: FSM states,
// the default word width and the bit-counter width helper.
package piso_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // A one-bit counter is still needed for the narrowest legal word.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer_32_bit.sv
// Parallel-in serial-out serializer, MSB first, with a one-word holding
// register so consecutive words stream out with no idle cycle between them.
module piso_serializer_32_bit
   import piso_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
   input  logic                  Load_Valid_In,
   output logic                  Load_Ready_Out,
   output logic                  Serial_Data_Out,
   output logic                  Serial_Valid_Out,
   output logic                  Frame_Start_Out,
   output logic                  Frame_Done_Out,
   output logic                  Busy_Out
);

   localparam int CW = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;

   logic accept;
   logic last_bit;
   logic in_shift;

   // Ready depends only on registered state, never on Load_Valid_In.
   assign accept   = Load_Valid_In && !hold_full_q;
   assign last_bit = (cnt_q == LAST_BIT);
   assign in_shift = (state_q == SHIFT);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = Parallel_Data_In;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (last_bit) begin
               // Handover: held word first, else a same-cycle bypass, else stop.
               cnt_d = '0;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_d      = '0;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  shift_d = Parallel_Data_In;
               end else begin
                  shift_d = '0;
                  state_d = IDLE;
               end
            end else begin
               shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + CW'(1);
               if (accept) begin
                  hold_d      = Parallel_Data_In;
                  hold_full_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   // Outputs decode registered state only, so reset clears them at once.
   assign Load_Ready_Out   = !hold_full_q;
   assign Serial_Data_Out  = in_shift && shift_q[DATA_WIDTH-1];
   assign Serial_Valid_Out = in_shift;
   assign Frame_Start_Out  = in_shift && (cnt_q == '0);
   assign Frame_Done_Out   = in_shift && last_bit;
   assign Busy_Out         = in_shift;

endmodule

// File: tb/tb_piso_serializer_32_bit.sv
// Directed bench for piso_serializer_32_bit: a negedge SIPO model collects
// each frame and every observation is checked by an immediate assertion.
module tb_piso_serializer_32_bit;

   logic        Clk_In = 1'b0;
   logic        Reset_In = 1'b0;
   logic [31:0] Parallel_Data_In = '0;
   logic        Load_Valid_In = 1'b0;
   logic        Load_Ready_Out;
   logic        Serial_Data_Out;
   logic        Serial_Valid_Out;
   logic        Frame_Start_Out;
   logic        Frame_Done_Out;
   logic        Busy_Out;

   int          checks = 0;
   int          passes = 0;
   logic [31:0] sipo = '0;
   logic [31:0] rx[$];
   logic [31:0] sent[$];
   int          validCycles = 0;
   int          readyLowCycles = 0;

   piso_serializer_32_bit #(.DATA_WIDTH(32)) dut (
      .Clk_In           (Clk_In),
      .Reset_In         (Reset_In),
      .Parallel_Data_In (Parallel_Data_In),
      .Load_Valid_In    (Load_Valid_In),
      .Load_Ready_Out   (Load_Ready_Out),
      .Serial_Data_Out  (Serial_Data_Out),
      .Serial_Valid_Out (Serial_Valid_Out),
      .Frame_Start_Out  (Frame_Start_Out),
      .Frame_Done_Out   (Frame_Done_Out),
      .Busy_Out         (Busy_Out)
   );

   always #5 Clk_In = ~Clk_In;

   // Free-running downstream SIPO, sampled mid-cycle where outputs are stable.
   always @(negedge Clk_In) begin
      if (Serial_Valid_Out) begin
         sipo = {sipo[30:0], Serial_Data_Out};
         validCycles++;
         if (Frame_Done_Out) rx.push_back(sipo);
      end
      if (Reset_In && !Load_Ready_Out) readyLowCycles++;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d);
      Load_Valid_In    = v;
      Parallel_Data_In = d;
   endtask

   task automatic tick();
      @(posedge Clk_In);
      #1;
   endtask

   task automatic waitIdle(input string tag, input int budget, output int n);
      n = 0;
      while (Busy_Out && n < budget) begin
         tick();
         n++;
      end
      checkOutput(tag, Busy_Out, 0);
   endtask

   function automatic logic [31:0] popRx();
      if (rx.size() == 0) return 'x;
      return rx.pop_front();
   endfunction

   initial begin
      logic [31:0] w;
      logic [31:0] words[3];
      int          n;
      int          k;
      int          cyc;
      int          bad;
      logic        acc;
      logic        v;
      logic [31:0] d;

      // Reset state
      applyStimulus(0, '0);
      repeat (2) @(posedge Clk_In);
      #1;
      checkOutput("rst_ready", Load_Ready_Out, 1);
      checkOutput("rst_valid", Serial_Valid_Out, 0);
      checkOutput("rst_data", Serial_Data_Out, 0);
      checkOutput("rst_busy", Busy_Out, 0);
      checkOutput("rst_start", Frame_Start_Out, 0);
      checkOutput("rst_done", Frame_Done_Out, 0);
      #3 Reset_In = 1'b1;
      tick();
      checkOutput("post_rst_ready", Load_Ready_Out, 1);
      checkOutput("post_rst_valid", Serial_Valid_Out, 0);

      // Single word, MSB first, latency one
      rx.delete();
      validCycles = 0;
      w = 32'hA5A5_0F0F;
      applyStimulus(1, w);
      tick();
      applyStimulus(0, '0);
      for (int i = 0; i < 32; i++) begin
         checkOutput("t1_valid", Serial_Valid_Out, 1);
         checkOutput("t1_bit", Serial_Data_Out, w[31-i]);
         checkOutput("t1_start", Frame_Start_Out, (i == 0));
         checkOutput("t1_done", Frame_Done_Out, (i == 31));
         checkOutput("t1_ready", Load_Ready_Out, 1);
         tick();
      end
      checkOutput("t1_idle_valid", Serial_Valid_Out, 0);
      checkOutput("t1_idle_busy", Busy_Out, 0);
      checkOutput("t1_valid_cycles", validCycles, 32);
      checkOutput("t1_word", popRx(), 32'hA5A5_0F0F);

      // Back-to-back through the holding register
      rx.delete();
      validCycles = 0;
      applyStimulus(1, 32'hDEAD_BEEF);
      tick();
      checkOutput("t2_ready_c1", Load_Ready_Out, 1);
      applyStimulus(1, 32'h1234_5678);
      tick();
      applyStimulus(0, '0);
      for (int c = 2; c <= 32; c++) begin
         checkOutput("t2_ready_low", Load_Ready_Out, 0);
         checkOutput("t2_valid", Serial_Valid_Out, 1);
         tick();
      end
      checkOutput("t2_ready_handover", Load_Ready_Out, 1);
      checkOutput("t2_start2", Frame_Start_Out, 1);
      checkOutput("t2_valid2", Serial_Valid_Out, 1);
      waitIdle("t2_idle", 40, n);
      checkOutput("t2_second_len", n, 32);
      checkOutput("t2_valid_cycles", validCycles, 64);
      checkOutput("t2_word0", popRx(), 32'hDEAD_BEEF);
      checkOutput("t2_word1", popRx(), 32'h1234_5678);

      // Bypass in the last-bit cycle
      rx.delete();
      validCycles = 0;
      readyLowCycles = 0;
      applyStimulus(1, 32'h0F0F_F0F0);
      tick();
      applyStimulus(0, '0);
      repeat (31) tick();
      checkOutput("t3_lastbit", Frame_Done_Out, 1);
      applyStimulus(1, 32'h3C3C_C3C3);
      tick();
      applyStimulus(0, '0);
      checkOutput("t3_start", Frame_Start_Out, 1);
      checkOutput("t3_valid", Serial_Valid_Out, 1);
      checkOutput("t3_ready", Load_Ready_Out, 1);
      waitIdle("t3_idle", 40, n);
      checkOutput("t3_second_len", n, 32);
      checkOutput("t3_ready_low", readyLowCycles, 0);
      checkOutput("t3_valid_cycles", validCycles, 64);
      checkOutput("t3_word0", popRx(), 32'h0F0F_F0F0);
      checkOutput("t3_word1", popRx(), 32'h3C3C_C3C3);

      // Backpressure with valid held high
      rx.delete();
      validCycles = 0;
      words[0] = 32'h8000_0001;
      words[1] = 32'h7FFF_FFFE;
      words[2] = 32'h1357_9BDF;
      k = 0;
      cyc = 0;
      while (k < 3 && cyc < 300) begin
         applyStimulus(1, words[k]);
         acc = Load_Ready_Out;
         tick();
         if (acc) k++;
         cyc++;
      end
      applyStimulus(0, '0);
      checkOutput("t4_accepts", k, 3);
      waitIdle("t4_idle", 100, n);
      checkOutput("t4_frames", rx.size(), 3);
      checkOutput("t4_valid_cycles", validCycles, 96);
      checkOutput("t4_word0", popRx(), 32'h8000_0001);
      checkOutput("t4_word1", popRx(), 32'h7FFF_FFFE);
      checkOutput("t4_word2", popRx(), 32'h1357_9BDF);

      // Reset mid-word with a word held
      rx.delete();
      applyStimulus(1, 32'hFFFF_FFFF);
      tick();
      applyStimulus(1, 32'h600D_F00D);
      tick();
      applyStimulus(0, '0);
      repeat (9) tick();
      checkOutput("t5_held", Load_Ready_Out, 0);
      checkOutput("t5_midword", Serial_Data_Out, 1);
      #2 Reset_In = 1'b0;
      #1;
      checkOutput("t5_rst_valid", Serial_Valid_Out, 0);
      checkOutput("t5_rst_data", Serial_Data_Out, 0);
      checkOutput("t5_rst_busy", Busy_Out, 0);
      checkOutput("t5_rst_done", Frame_Done_Out, 0);
      checkOutput("t5_rst_ready", Load_Ready_Out, 1);
      repeat (2) @(posedge Clk_In);
      #3 Reset_In = 1'b1;
      rx.delete();
      validCycles = 0;
      tick();
      repeat (40) tick();
      checkOutput("t5_no_resume", validCycles, 0);
      checkOutput("t5_no_frames", rx.size(), 0);
      checkOutput("t5_ready_after", Load_Ready_Out, 1);

      // Random words with random valid gaps
      rx.delete();
      sent.delete();
      cyc = 0;
      while (sent.size() < 1000 && cyc < 60000) begin
         v = ($urandom_range(0, 3) != 0);
         d = $urandom;
         applyStimulus(v, d);
         if (v && Load_Ready_Out) sent.push_back(d);
         tick();
         cyc++;
      end
      applyStimulus(0, '0);
      waitIdle("t6_idle", 100, n);
      checkOutput("t6_sent", sent.size(), 1000);
      checkOutput("t6_frames", rx.size(), sent.size());
      bad = 0;
      for (int i = 0; i < sent.size() && i < rx.size(); i++) begin
         if (rx[i] !== sent[i]) bad++;
      end
      checkOutput("t6_word_mismatches", bad, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
